conv_maxpool_2x2: RTL and testbench
===================================

Name: conv_maxpool_2x2

Overview:
- Downstream stage of the CNN convolution engine.
- Consumes the 16-channel convolved pixel stream: 14x14 map, one 128-bit beat per pixel position, channels packed 8 bits each.
- Applies 2x2 stride-2 max pooling per channel and emits a 7x7x16 pooled map, one 128-bit beat per pooled position, in raster order, to the flatten/dense stage.

Parameters:
- NUM_CH, 16, channels per beat
- DATA_W, 8, bits per channel
- IN_COLS, 14, input map width; must be even
- IN_ROWS, 14, input map height; must be even

Ports:
- axi_clk  input  1  clock; all logic on rising edge
- axi_rst  input  1  reset, synchronous, active-high
- i_data_valid  input  NUM_CH  per-channel valid from the conv engine; a beat is accepted only when all bits are 1
- i_data  input  NUM_CH*DATA_W  convolved pixel; channel k occupies bits [k*DATA_W +: DATA_W]
- o_data_valid  output  1  pooled beat valid, single-cycle pulse
- o_data  output  NUM_CH*DATA_W  pooled pixel, same channel packing
- o_out_col  output  3  pooled column index of the current o_data (0..6)
- o_out_row  output  3  pooled row index of the current o_data (0..6)
- o_frame_done  output  1  one-cycle pulse, asserted with the last pooled beat of a frame
- o_busy  output  1  high while a frame is partially received

Behaviour:
- Reset values (axi_rst high at a clock edge): o_data_valid=0, o_data=0, o_out_col=0, o_out_row=0, o_frame_done=0, o_busy=0.
- Reset also clears the column counter, row counter, horizontal hold register and line buffer, and puts the FSM in IDLE.
- Reset mid-frame discards the partial frame; the next accepted beat is row 0, col 0.
- Accept condition: &i_data_valid. Beats with partial valid are ignored and do not advance the counters. There is no backpressure; the block must accept one beat every cycle.
- Counters: in_col runs 0..IN_COLS-1 and in_row runs 0..IN_ROWS-1. in_col increments on each accepted beat; when it wraps, in_row increments.
- Even in_col: beat is stored in the hold register.
- Odd in_col: pair = per-channel max(hold, beat).
  - Even in_row: pair is written to line buffer entry in_col>>1. The buffer has IN_COLS/2 entries of NUM_CH*DATA_W bits.
  - Odd in_row: result = per-channel max(linebuf[in_col>>1], pair). It is registered to o_data with o_data_valid=1 on the next cycle.
- Latency: exactly 1 clock from the accepting edge of an odd-row, odd-col beat to o_data_valid high.
- Output indices: o_out_col = in_col>>1 and o_out_row = in_row>>1 of the producing beat. They are held until the next output.
- Compare: unsigned per channel by default. Ties give the equal value.
- FSM:
  - IDLE: no beat of the frame yet; o_busy=0. An accepted beat moves to RUN.
  - RUN: o_busy=1. Acceptance of the beat at (IN_ROWS-1, IN_COLS-1) moves to DONE.
  - DONE: exactly one cycle. o_frame_done=1 together with the final o_data_valid. Counters are already 0. Always returns to IDLE.
- Simultaneous events:
  - A beat accepted while in DONE is treated as row 0, col 0 of the next frame; FSM goes to RUN.
  - axi_rst has priority over any beat.
- Gaps: idle cycles between beats (e.g. while the conv engine waits for input rows) do not disturb state; the line buffer persists across gaps.
- Parameter legality: odd IN_COLS or IN_ROWS is illegal; the implementation halts elaboration with an error.

Optional Feature:
- Macro: MAXPOOL_RELU_EN
- Defined: each channel is treated as signed two's complement. Negative values are clamped to 0 before the hold-register and line-buffer stores, so outputs equal max(0, window max). o_data is therefore never negative.
- Undefined: unsigned compare, no clamping. Bit patterns pass through the max unchanged.

Test Plan:
- Ramp frame: channel k of pixel (r,c) = r*14+c, all valid=16'hffff, one beat per cycle → 49 outputs. Output (pr,pc) channel k = (2pr+1)*14+2pc+1, e.g. (0,0)=15 and (6,6)=195. o_frame_done pulses only with (6,6).
- Max position: window (0,0) channel 3 values 5,200,7,9; other channels 0 → output (0,0) ch3=200 and all other channels 0. Repeat with the 200 in each of the four window positions.
- Partial valid: inject a beat with i_data_valid=16'h7fff and data 8'hff mid-row → ignored. Counters are unchanged and outputs match the ramp reference.
- Gapped input: 3 idle cycles after every 14 beats, plus a 50-cycle gap after row 6 → outputs identical to the ramp test. o_busy stays 1 throughout and is 0 only after DONE.
- Reset mid-frame: axi_rst for 1 cycle after row 5, then a full ramp frame → all outputs 0 in the reset cycle, exactly 49 correct outputs follow, first output index (0,0).
- Back-to-back frames plus MAXPOOL_RELU_EN: second frame starts in the DONE cycle → 98 outputs, two o_frame_done pulses. With MAXPOOL_RELU_EN defined, a window of 8'h80,8'hf0,8'hff,8'h81 gives 8'h00; undefined, it gives 8'hff.

Source files
------------

// File: rtl/conv_maxpool_2x2.sv
// 2x2 stride-2 max pooling over a packed multi-channel pixel stream, one beat per cycle.
// Optional MAXPOOL_RELU_EN: channels are signed and negative values are clamped to 0 first.
module conv_maxpool_2x2 #(
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IN_COLS = 14,
  parameter int unsigned IN_ROWS = 14
) (
  input  logic                       axi_clk,
  input  logic                       axi_rst,
  input  logic [NUM_CH-1:0]          i_data_valid,
  input  logic [NUM_CH*DATA_W-1:0]   i_data,
  output logic                       o_data_valid,
  output logic [NUM_CH*DATA_W-1:0]   o_data,
  output logic [2:0]                 o_out_col,
  output logic [2:0]                 o_out_row,
  output logic                       o_frame_done,
  output logic                       o_busy
);

  localparam int unsigned BeatW   = NUM_CH * DATA_W;
  localparam int unsigned ColW    = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int unsigned RowW    = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int unsigned Entries = (IN_COLS > 1) ? IN_COLS / 2 : 1;
  localparam int unsigned IdxW    = (Entries > 1) ? $clog2(Entries) : 1;

  if ((IN_COLS % 2) != 0 || IN_COLS < 2) begin : g_bad_cols
    $error("conv_maxpool_2x2: IN_COLS must be even and at least 2");
  end
  if ((IN_ROWS % 2) != 0 || IN_ROWS < 2) begin : g_bad_rows
    $error("conv_maxpool_2x2: IN_ROWS must be even and at least 2");
  end
  if (IN_COLS > 16 || IN_ROWS > 16) begin : g_bad_size
    $error("conv_maxpool_2x2: pooled indices must fit the 3-bit output ports");
  end

  typedef logic [BeatW-1:0] beat_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic beat_t relu_beat(beat_t b);
    beat_t r;
    r = b;
`ifdef MAXPOOL_RELU_EN
    for (int k = 0; k < NUM_CH; k++) begin
      if (b[k*DATA_W + DATA_W - 1]) begin
        r[k*DATA_W +: DATA_W] = '0;
      end
    end
`endif
    return r;
  endfunction

  // Unsigned compare; with clamping enabled every operand is already non-negative,
  // so this also matches a signed compare.
  function automatic beat_t max_beat(beat_t a, beat_t b);
    beat_t r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      r[k*DATA_W +: DATA_W] = (a[k*DATA_W +: DATA_W] >= b[k*DATA_W +: DATA_W]) ?
                              a[k*DATA_W +: DATA_W] : b[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [ColW-1:0] in_col_q, in_col_d;
  logic [RowW-1:0] in_row_q, in_row_d;
  beat_t           hold_q, hold_d;
  beat_t           linebuf_q [Entries];
  beat_t           linebuf_d [Entries];
  beat_t           data_q, data_d;
  logic            valid_q, valid_d;
  logic [2:0]      out_col_q, out_col_d;
  logic [2:0]      out_row_q, out_row_d;

  logic            accept;
  logic            col_last;
  logic            row_last;
  logic [IdxW-1:0] idx;
  beat_t           beat_c;
  beat_t           pair;

  always_comb begin
    accept   = &i_data_valid;
    col_last = (in_col_q == ColW'(IN_COLS - 1));
    row_last = (in_row_q == RowW'(IN_ROWS - 1));
    idx      = IdxW'(in_col_q >> 1);
    beat_c   = relu_beat(i_data);
    pair     = max_beat(hold_q, beat_c);
  end

  // Datapath: even columns park in the hold register, odd columns close a horizontal pair.
  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    hold_d    = hold_q;
    linebuf_d = linebuf_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    out_col_d = out_col_q;
    out_row_d = out_row_q;

    if (accept) begin
      if (!in_col_q[0]) begin
        hold_d = beat_c;
      end else if (!in_row_q[0]) begin
        linebuf_d[idx] = pair;
      end else begin
        data_d    = max_beat(linebuf_q[idx], pair);
        valid_d   = 1'b1;
        out_col_d = 3'(in_col_q >> 1);
        out_row_d = 3'(in_row_q >> 1);
      end

      if (col_last) begin
        in_col_d = '0;
        in_row_d = row_last ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (col_last && row_last) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept && col_last && row_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // A beat here is pixel (0,0) of the next frame.
        if (accept) begin
          state_d = (col_last && row_last) ? StDone : StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q   <= StIdle;
      in_col_q  <= '0;
      in_row_q  <= '0;
      hold_q    <= '0;
      linebuf_q <= '{default: '0};
      data_q    <= '0;
      valid_q   <= 1'b0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      hold_q    <= hold_d;
      linebuf_q <= linebuf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
    end
  end

  always_comb begin
    o_data_valid = valid_q;
    o_data       = data_q;
    o_out_col    = out_col_q;
    o_out_row    = out_row_q;
    o_frame_done = (state_q == StDone);
    o_busy       = (state_q == StRun);
  end

endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Scoreboard bench for conv_maxpool_2x2: directed frames push expected pooled beats,
// an independent monitor pops and compares whenever the DUT emits a beat.
module tb_conv_maxpool_2x2;

  localparam int MRamp = 0;
  localparam int MMax  = 1;
  localparam int MRelu = 2;

  logic         axi_clk = 1'b0;
  logic         axi_rst;
  logic [15:0]  i_data_valid;
  logic [127:0] i_data;
  logic         o_data_valid;
  logic [127:0] o_data;
  logic [2:0]   o_out_col;
  logic [2:0]   o_out_row;
  logic         o_frame_done;
  logic         o_busy;

  always #5 axi_clk = ~axi_clk;

  conv_maxpool_2x2 #(
    .NUM_CH (16),
    .DATA_W (8),
    .IN_COLS(14),
    .IN_ROWS(14)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .i_data_valid(i_data_valid),
    .i_data      (i_data),
    .o_data_valid(o_data_valid),
    .o_data      (o_data),
    .o_out_col   (o_out_col),
    .o_out_row   (o_out_row),
    .o_frame_done(o_frame_done),
    .o_busy      (o_busy)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [2:0]   col;
    logic [2:0]   row;
    logic         done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   frames_exp = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Input pixel for a directed frame.
  function automatic logic [127:0] pix(input int mode, input int pos, input int r, input int c);
    logic [127:0] d;
    logic [7:0]   oth [3];
    logic [7:0]   rv  [4];
    int           w;
    d = '0;
    w = r * 2 + c;
    oth = '{8'd5, 8'd7, 8'd9};
    rv  = '{8'h80, 8'hf0, 8'hff, 8'h81};
    case (mode)
      MRamp: d = {16{8'(r * 14 + c)}};
      MMax: begin
        if (r < 2 && c < 2) begin
          d[3*8 +: 8] = (w == pos) ? 8'd200 : oth[(w < pos) ? w : w - 1];
        end
      end
      MRelu: begin
        if (r < 2 && c < 2) d = {16{rv[w]}};
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Expected pooled beat.
  function automatic logic [127:0] expv(input int mode, input int pr, input int pc);
    logic [127:0] d;
`ifdef MAXPOOL_RELU_EN
    int base;
    int vals [4];
    int m;
`endif
    d = '0;
    case (mode)
      MRamp: begin
`ifdef MAXPOOL_RELU_EN
        base = 2 * pr * 14 + 2 * pc;
        vals = '{base, base + 1, base + 14, base + 15};
        m = 0;
        for (int i = 0; i < 4; i++) if (vals[i] < 128 && vals[i] > m) m = vals[i];
        d = {16{8'(m)}};
`else
        d = {16{8'((2 * pr + 1) * 14 + 2 * pc + 1)}};
`endif
      end
      MMax: if (pr == 0 && pc == 0) d[3*8 +: 8] = 8'd200;
      MRelu: begin
`ifdef MAXPOOL_RELU_EN
        if (pr == 0 && pc == 0) d = {16{8'h00}};
`else
        if (pr == 0 && pc == 0) d = {16{8'hff}};
`endif
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  task automatic beat(input logic [127:0] d, input logic [15:0] v);
    i_data       = d;
    i_data_valid = v;
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_data_valid = '0;
    i_data       = {16{8'ha5}};
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic frame(input int mode, input int pos, input bit gapped, input bit partial,
                       input int stop_row);
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < 14; c++) begin
        if (partial && r == 3 && c == 5) beat({16{8'hff}}, 16'h7fff);
        if ((r % 2) == 1 && (c % 2) == 1) begin
          q.push_back('{data: expv(mode, r / 2, c / 2), col: 3'(c / 2), row: 3'(r / 2),
                        done: (r == 13 && c == 13)});
        end
        beat(pix(mode, pos, r, c), 16'hffff);
      end
      if (r == stop_row) return;
      if (gapped && r < 13) begin
        idle(3);
        check("busy_in_row_gap", 128'(o_busy), 128'(1));
        if (r == 6) begin
          idle(25);
          check("busy_in_long_gap", 128'(o_busy), 128'(1));
          idle(25);
        end
      end
    end
    frames_exp++;
  endtask

  always @(negedge axi_clk) begin
    if (o_data_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got beat at (%0d,%0d) required none", o_out_row,
                 o_out_col);
      end else begin
        e = q.pop_front();
        check("out_data", o_data, e.data);
        check("out_col", 128'(o_out_col), 128'(e.col));
        check("out_row", 128'(o_out_row), 128'(e.row));
        check("frame_done", 128'(o_frame_done), 128'(e.done));
      end
      if (o_frame_done) n_done++;
    end else if (o_frame_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_done_without_valid: got 1 required 0 (t=%0t)", $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    axi_rst      = 1'b1;
    i_data_valid = '0;
    i_data       = '0;
    repeat (2) @(posedge axi_clk);
    #1;
    check("rst_valid", 128'(o_data_valid), 128'(0));
    check("rst_data", o_data, 128'(0));
    check("rst_col", 128'(o_out_col), 128'(0));
    check("rst_row", 128'(o_out_row), 128'(0));
    check("rst_done", 128'(o_frame_done), 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    axi_rst = 1'b0;
    idle(2);

    // Ramp, then ramp with a partially valid beat injected mid-row.
    frame(MRamp, 0, 1'b0, 1'b0, -1);
    idle(3);
    check("busy_after_ramp", 128'(o_busy), 128'(0));
    frame(MRamp, 0, 1'b0, 1'b1, -1);
    idle(3);

    // Gapped input.
    frame(MRamp, 0, 1'b1, 1'b0, -1);
    idle(3);
    check("busy_after_gapped", 128'(o_busy), 128'(0));

    // Reset after row 5, then a full frame.
    frame(MRamp, 0, 1'b0, 1'b0, 5);
    axi_rst      = 1'b1;
    i_data_valid = '0;
    @(posedge axi_clk);
    #1;
    check("midrst_valid", 128'(o_data_valid), 128'(0));
    check("midrst_data", o_data, 128'(0));
    check("midrst_col", 128'(o_out_col), 128'(0));
    check("midrst_row", 128'(o_out_row), 128'(0));
    check("midrst_busy", 128'(o_busy), 128'(0));
    axi_rst = 1'b0;
    frame(MRamp, 0, 1'b0, 1'b0, -1);
    idle(3);

    // Max at each of the four window positions.
    for (int p = 0; p < 4; p++) begin
      frame(MMax, p, 1'b0, 1'b0, -1);
      idle(2);
    end

    // Back-to-back frames: second frame's first beat lands in the done cycle.
    frame(MRamp, 0, 1'b0, 1'b0, -1);
    frame(MRamp, 0, 1'b0, 1'b0, -1);
    idle(3);

    frame(MRelu, 0, 1'b0, 1'b0, -1);
    idle(5);

    check("scoreboard_drained", 128'(q.size()), 128'(0));
    check("frame_done_count", 128'(n_done), 128'(frames_exp));
    check("busy_final", 128'(o_busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
